// File: rtl/br_pkg.sv
// Shared types and constants for the branch prediction unit.
// Contents: condition-code encodings, PHT counter constants, the
// {zr,ov,neg} flag vector and a condition evaluation helper.
package br_pkg;

    typedef enum logic [2:0] {
        CC_NE   = 3'b000,
        CC_EQ   = 3'b001,
        CC_GT   = 3'b010,
        CC_LT   = 3'b011,
        CC_GTE  = 3'b100,
        CC_LTE  = 3'b101,
        CC_OVFL = 3'b110,
        CC_UNC  = 3'b111
    } cc_e;

    localparam logic [1:0] PHT_RST = 2'b01;
    localparam logic [1:0] SAT_MAX = 2'd3;
    localparam logic [1:0] SAT_MIN = 2'd0;

    typedef struct packed {
        logic zr;
        logic ov;
        logic neg;
    } flags_t;

    // Branch-taken decision for a condition code against the flag registers.
    function automatic logic cc_eval(input cc_e cc, input flags_t f);
        logic res;
        res = 1'b0;
        case (cc)
            CC_NE:   res = ~f.zr;
            CC_EQ:   res = f.zr;
            CC_GT:   res = ~f.zr & ~f.neg;
            CC_LT:   res = f.neg;
            CC_GTE:  res = f.zr | ~f.neg;
            CC_LTE:  res = f.neg | f.zr;
            CC_OVFL: res = f.ov;
            CC_UNC:  res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/br_pht.sv
// Pattern history table of 2-bit saturating counters.
// Ports:
//   clk, rst        clock, async active-high reset (counters -> weakly not-taken)
//   lookup_idx_i    fetch-side index; pred_taken_o is counter MSB (pre-update value)
//   upd_en_i        update the counter at upd_idx_i on the next edge
//   upd_idx_i       index of the resolving branch
//   upd_taken_i     resolved direction: increment when 1, decrement when 0
module br_pht
    import br_pkg::*;
#(
    parameter  int unsigned ENTRIES = 64,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             pred_taken_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    logic [1:0] cnt_q [ENTRIES];
    logic [1:0] cnt_d [ENTRIES];

    // Lookup reads registered state only, so a same-cycle update is not visible.
    assign pred_taken_o = cnt_q[lookup_idx_i][1];

    // Saturating counter update for the resolving branch.
    always_comb begin
        cnt_d = cnt_q;
        if (upd_en_i) begin
            if (upd_taken_i) begin
                if (cnt_q[upd_idx_i] != SAT_MAX) begin
                    cnt_d[upd_idx_i] = cnt_q[upd_idx_i] + 2'd1;
                end
            end else begin
                if (cnt_q[upd_idx_i] != SAT_MIN) begin
                    cnt_d[upd_idx_i] = cnt_q[upd_idx_i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= PHT_RST;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/br_pred_unit.sv
// Branch resolution, direction prediction and flag save/restore stack.
// Ports:
//   clk, rst, stall                  clock, async active-high reset, global freeze
//   clk_z_ID_EX / clk_nv_ID_EX       latch zr / latch ov,neg into the flag registers
//   br_instr/jmp_imm/jmp_reg_ID_EX   instruction class in EX
//   cc_ID_EX, zr, ov, neg            condition code and ALU flags
//   pc_IF, pc_ID_EX                  fetch PC (lookup) and EX PC (update)
//   pred_taken_ID_EX                 prediction that travelled with the EX instruction
//   flag_push / flag_pop             save / restore flags (interrupt entry / return)
//   flow_change_ID_EX                take branch/jump (combinational)
//   mispredict_ID_EX                 branch direction differs from prediction (combinational)
//   pred_taken_IF                    prediction for pc_IF
//   zr/ov/neg_EX_DM                  flag registers
//   stack_empty, stack_full          stack occupancy status
//   stack_err                        sticky overflow/underflow
module br_pred_unit
    import br_pkg::*;
#(
    parameter int unsigned PC_W        = 16,
    parameter int unsigned PHT_ENTRIES = 64,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            clk_z_ID_EX,
    input  logic            clk_nv_ID_EX,
    input  logic            br_instr_ID_EX,
    input  logic            jmp_imm_ID_EX,
    input  logic            jmp_reg_ID_EX,
    input  logic [2:0]      cc_ID_EX,
    input  logic            zr,
    input  logic            ov,
    input  logic            neg,
    input  logic [PC_W-1:0] pc_IF,
    input  logic [PC_W-1:0] pc_ID_EX,
    input  logic            pred_taken_ID_EX,
    input  logic            flag_push,
    input  logic            flag_pop,
    output logic            flow_change_ID_EX,
    output logic            mispredict_ID_EX,
    output logic            pred_taken_IF,
    output logic            zr_EX_DM,
    output logic            ov_EX_DM,
    output logic            neg_EX_DM,
    output logic            stack_empty,
    output logic            stack_full,
    output logic            stack_err
);

    localparam int unsigned IDX_W = $clog2(PHT_ENTRIES);
    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    flags_t           flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    flags_t           stack_q [STACK_DEPTH];

    logic             stk_we;
    logic [SP_W-1:0]  stk_widx;
    flags_t           stk_wdata;
    logic [SP_W-1:0]  top_idx;
    logic [SP_W-1:0]  push_idx;
    logic             empty_c, full_c;
    logic             pht_upd_en;

    // Only the low PC bits index the PHT; higher bits alias.
    if (PC_W > IDX_W) begin : g_pc_hi
        logic unused_pc_hi;
        assign unused_pc_hi = ^{pc_IF[PC_W-1:IDX_W], pc_ID_EX[PC_W-1:IDX_W]};
    end

    // Branch/jump resolution against the registered flags.
    assign flow_change_ID_EX = br_instr_ID_EX ? cc_eval(cc_e'(cc_ID_EX), flags_q)
                                              : (jmp_imm_ID_EX | jmp_reg_ID_EX);
    assign mispredict_ID_EX  = br_instr_ID_EX & (flow_change_ID_EX ^ pred_taken_ID_EX);

    assign pht_upd_en = br_instr_ID_EX & ~stall;

    br_pht #(
        .ENTRIES (PHT_ENTRIES)
    ) u_pht (
        .clk          (clk),
        .rst          (rst),
        .lookup_idx_i (pc_IF[IDX_W-1:0]),
        .pred_taken_o (pred_taken_IF),
        .upd_en_i     (pht_upd_en),
        .upd_idx_i    (pc_ID_EX[IDX_W-1:0]),
        .upd_taken_i  (flow_change_ID_EX)
    );

    assign empty_c  = (cnt_q == '0);
    assign full_c   = (cnt_q == CNT_W'(STACK_DEPTH));
    assign top_idx  = SP_W'(cnt_q - CNT_W'(1));
    assign push_idx = SP_W'(cnt_q);

    // Flag latching and stack control; pop/swap writes override ALU latching.
    always_comb begin
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        stk_we    = 1'b0;
        stk_widx  = push_idx;
        stk_wdata = flags_q;
        if (!stall) begin
            if (clk_z_ID_EX) begin
                flags_d.zr = zr;
            end
            if (clk_nv_ID_EX) begin
                flags_d.ov  = ov;
                flags_d.neg = neg;
            end
            if (flag_push && flag_pop && !empty_c) begin
                // Swap: top takes current flags, flags take old top.
                stk_we   = 1'b1;
                stk_widx = top_idx;
                flags_d  = stack_q[top_idx];
            end else if (flag_push) begin
                if (full_c) begin
                    err_d = 1'b1;
                end else begin
                    stk_we = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end else if (flag_pop) begin
                if (empty_c) begin
                    err_d = 1'b1;
                end else begin
                    flags_d = stack_q[top_idx];
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Stack storage holds no reset value; a reset clears the count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (stk_we) begin
            stack_q[stk_widx] <= stk_wdata;
        end
    end

    assign zr_EX_DM    = flags_q.zr;
    assign ov_EX_DM    = flags_q.ov;
    assign neg_EX_DM   = flags_q.neg;
    assign stack_empty = empty_c;
    assign stack_full  = full_c;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_br_pred_unit.sv
// Self-checking bench for br_pred_unit: vector table, directed sequences and
// randomized stimulus against a queue/array reference model.
module tb_br_pred_unit;

    localparam int unsigned PC_W = 16;
    localparam int unsigned N    = 64;
    localparam int unsigned D    = 4;

    logic clk = 1'b0;
    logic rst, stall, clk_z, clk_nv, br, jimm, jreg;
    logic [2:0] cc;
    logic zr, ov, neg, pred_in, push, pop;
    logic [PC_W-1:0] pc_IF, pc_EX;
    logic fc_o, mis_o, pred_o, zr_o, ov_o, neg_o, empty_o, full_o, err_o;

    always #5 clk = ~clk;

    br_pred_unit #(.PC_W(PC_W), .PHT_ENTRIES(N), .STACK_DEPTH(D)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .clk_z_ID_EX       (clk_z),
        .clk_nv_ID_EX      (clk_nv),
        .br_instr_ID_EX    (br),
        .jmp_imm_ID_EX     (jimm),
        .jmp_reg_ID_EX     (jreg),
        .cc_ID_EX          (cc),
        .zr                (zr),
        .ov                (ov),
        .neg               (neg),
        .pc_IF             (pc_IF),
        .pc_ID_EX          (pc_EX),
        .pred_taken_ID_EX  (pred_in),
        .flag_push         (push),
        .flag_pop          (pop),
        .flow_change_ID_EX (fc_o),
        .mispredict_ID_EX  (mis_o),
        .pred_taken_IF     (pred_o),
        .zr_EX_DM          (zr_o),
        .ov_EX_DM          (ov_o),
        .neg_EX_DM         (neg_o),
        .stack_empty       (empty_o),
        .stack_full        (full_o),
        .stack_err         (err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit       mz, mv, mn, merr;
    bit [2:0] stk[$];
    int       pht[N];

    typedef struct {
        logic [2:0] cc;
        logic [2:0] flags;   // {zr,ov,neg}
        logic       exp_fc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_fc();
        if (br) begin
            case (cc)
                3'd0: return !mz;
                3'd1: return mz;
                3'd2: return !mz && !mn;
                3'd3: return mn;
                3'd4: return mz || !mn;
                3'd5: return mn || mz;
                3'd6: return mv;
                default: return 1'b1;
            endcase
        end
        return jimm || jreg;
    endfunction

    task automatic model_reset();
        mz = 0; mv = 0; mn = 0; merr = 0;
        stk.delete();
        for (int i = 0; i < N; i++) pht[i] = 1;
    endtask

    task automatic model_edge();
        bit f;
        int idx;
        bit [2:0] cur, nxt, top;
        if (rst) begin
            model_reset();
            return;
        end
        if (stall) return;
        f = m_fc();
        if (br) begin
            idx = int'(pc_EX) % N;
            if (f) pht[idx] = (pht[idx] < 3) ? pht[idx] + 1 : 3;
            else   pht[idx] = (pht[idx] > 0) ? pht[idx] - 1 : 0;
        end
        cur = {mz, mv, mn};
        nxt = cur;
        if (clk_z)  nxt[2] = zr;
        if (clk_nv) begin nxt[1] = ov; nxt[0] = neg; end
        if (push && pop && stk.size() > 0) begin
            top = stk[stk.size()-1];
            stk[stk.size()-1] = cur;
            nxt = top;
        end else if (push) begin
            if (stk.size() == D) merr = 1;
            else stk.push_back(cur);
        end else if (pop) begin
            if (stk.size() == 0) merr = 1;
            else nxt = stk.pop_back();
        end
        {mz, mv, mn} = nxt;
    endtask

    task automatic check_comb();
        bit f;
        f = m_fc();
        chk("flow_change", 32'(fc_o), 32'(f));
        chk("mispredict", 32'(mis_o), 32'(br && (f != pred_in)));
        chk("pred_taken_IF", 32'(pred_o), 32'(pht[int'(pc_IF) % N] >= 2));
    endtask

    task automatic check_regs();
        chk("flags", 32'({zr_o, ov_o, neg_o}), 32'({mz, mv, mn}));
        chk("stack_empty", 32'(empty_o), 32'(stk.size() == 0));
        chk("stack_full", 32'(full_o), 32'(stk.size() == D));
        chk("stack_err", 32'(err_o), 32'(merr));
    endtask

    // One cycle: combinational checks, clock edge, model update, register checks.
    task automatic step();
        #1;
        if (rst) model_reset();
        check_comb();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic idle();
        stall = 0; clk_z = 0; clk_nv = 0; br = 0; jimm = 0; jreg = 0;
        cc = 3'd0; zr = 0; ov = 0; neg = 0; pred_in = 0; push = 0; pop = 0;
        pc_IF = '0; pc_EX = '0;
    endtask

    task automatic set_flags(input logic [2:0] f);
        idle();
        clk_z = 1; clk_nv = 1; {zr, ov, neg} = f;
        step();
    endtask

    vec_t     tv[$];
    logic [2:0] vals [6];
    logic [2:0] pops [4];

    initial begin
        tv.push_back('{3'b000, 3'b000, 1'b1});
        tv.push_back('{3'b000, 3'b100, 1'b0});
        tv.push_back('{3'b001, 3'b100, 1'b1});
        tv.push_back('{3'b001, 3'b000, 1'b0});
        tv.push_back('{3'b010, 3'b000, 1'b1});
        tv.push_back('{3'b010, 3'b001, 1'b0});
        tv.push_back('{3'b010, 3'b100, 1'b0});
        tv.push_back('{3'b011, 3'b001, 1'b1});
        tv.push_back('{3'b011, 3'b000, 1'b0});
        tv.push_back('{3'b100, 3'b100, 1'b1});
        tv.push_back('{3'b100, 3'b001, 1'b0});
        tv.push_back('{3'b100, 3'b000, 1'b1});
        tv.push_back('{3'b101, 3'b001, 1'b1});
        tv.push_back('{3'b101, 3'b000, 1'b0});
        tv.push_back('{3'b110, 3'b010, 1'b1});
        tv.push_back('{3'b110, 3'b101, 1'b0});
        tv.push_back('{3'b111, 3'b000, 1'b1});

        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_regs();
        chk("reset_flags", 32'({zr_o, ov_o, neg_o}), 32'd0);
        chk("reset_empty", 32'(empty_o), 32'd1);
        chk("reset_pred", 32'(pred_o), 32'd0);

        // zr latch, cc evaluation, stall hold
        idle(); clk_z = 1; zr = 1;
        step();
        chk("zr_latch", 32'(zr_o), 32'd1);
        idle(); br = 1; cc = 3'b001;
        #1 chk("cc001_fc", 32'(fc_o), 32'd1);
        cc = 3'b000;
        #1 chk("cc000_fc", 32'(fc_o), 32'd0);
        idle(); stall = 1; clk_z = 1; zr = 0;
        step();
        chk("zr_stall_hold", 32'(zr_o), 32'd1);

        // jump: flow change, no mispredict, no PHT training
        idle(); jimm = 1; pc_EX = 16'h0010; pc_IF = 16'h0010;
        #1;
        chk("jmp_fc", 32'(fc_o), 32'd1);
        chk("jmp_mispredict", 32'(mis_o), 32'd0);
        step();
        idle(); pc_IF = 16'h0010;
        #1 chk("jmp_no_pht", 32'(pred_o), 32'd0);

        // cc table
        for (int i = 0; i < tv.size(); i++) begin
            set_flags(tv[i].flags);
            idle(); br = 1; cc = tv[i].cc; pc_EX = 16'h0120 + 16'(i); pred_in = 0;
            #1;
            chk($sformatf("tbl%0d_fc", i), 32'(fc_o), 32'(tv[i].exp_fc));
            chk($sformatf("tbl%0d_mispredict", i), 32'(mis_o), 32'(tv[i].exp_fc));
            step();
        end
        idle(); jreg = 1;
        #1 chk("jreg_fc", 32'(fc_o), 32'd1);

        // PHT saturation and aliasing
        set_flags(3'b000);
        idle(); br = 1; cc = 3'b111; pc_EX = 16'h0005;
        repeat (3) step();
        idle(); pc_IF = 16'h0045;
        #1 chk("pht_alias_taken", 32'(pred_o), 32'd1);
        idle(); br = 1; cc = 3'b001; pc_EX = 16'h0005; pc_IF = 16'h0045;
        step();
        #1 chk("pht_sat_11_to_10", 32'(pred_o), 32'd1);
        step();
        #1 chk("pht_10_to_01", 32'(pred_o), 32'd0);

        // stack overflow / LIFO / underflow
        vals[0] = 3'b101; vals[1] = 3'b010; vals[2] = 3'b110;
        vals[3] = 3'b011; vals[4] = 3'b111; vals[5] = 3'b000;
        pops[0] = 3'b011; pops[1] = 3'b110; pops[2] = 3'b010; pops[3] = 3'b101;
        set_flags(vals[0]);
        for (int k = 1; k < 6; k++) begin
            idle(); push = 1; clk_z = 1; clk_nv = 1; {zr, ov, neg} = vals[k];
            step();
        end
        chk("ovf_full", 32'(full_o), 32'd1);
        chk("ovf_err", 32'(err_o), 32'd1);
        chk("ovf_flags_latched", 32'({zr_o, ov_o, neg_o}), 32'(3'b000));
        for (int k = 0; k < 4; k++) begin
            idle(); pop = 1;
            step();
            chk($sformatf("lifo_pop%0d", k), 32'({zr_o, ov_o, neg_o}), 32'(pops[k]));
        end
        chk("pop_empty", 32'(empty_o), 32'd1);
        idle(); pop = 1;
        step();
        chk("unf_flags_hold", 32'({zr_o, ov_o, neg_o}), 32'(3'b101));
        chk("unf_err_sticky", 32'(err_o), 32'd1);

        // swap, then pop overriding clk_z
        set_flags(3'b011);
        idle(); push = 1; clk_z = 1; clk_nv = 1; {zr, ov, neg} = 3'b100;
        step();
        idle(); push = 1; pop = 1;
        step();
        chk("swap_flags", 32'({zr_o, ov_o, neg_o}), 32'(3'b011));
        chk("swap_count", 32'(empty_o), 32'd0);
        idle(); pop = 1;
        step();
        chk("swap_top", 32'({zr_o, ov_o, neg_o}), 32'(3'b100));
        idle(); push = 1;
        step();
        set_flags(3'b000);
        idle(); pop = 1; clk_z = 1; zr = 0;
        step();
        chk("pop_beats_clkz", 32'({zr_o, ov_o, neg_o}), 32'(3'b100));

        // asynchronous reset mid-cycle during a push
        idle(); push = 1; clk_z = 1; zr = 1; pc_IF = 16'h0120;
        #1 chk("pre_rst_pred", 32'(pred_o), 32'd1);
        #2 rst = 1;
        #1;
        chk("arst_flags", 32'({zr_o, ov_o, neg_o}), 32'd0);
        chk("arst_empty", 32'(empty_o), 32'd1);
        chk("arst_full", 32'(full_o), 32'd0);
        chk("arst_err", 32'(err_o), 32'd0);
        for (int i = 0; i < N; i++) begin
            pc_IF = PC_W'(i);
            #0.5 chk($sformatf("arst_pred%0d", i), 32'(pred_o), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("arst_push_discarded", 32'(empty_o), 32'd1);
        chk("arst_zr_discarded", 32'(zr_o), 32'd0);
        rst = 0;
        model_reset();

        // randomized against the model
        for (int it = 0; it < 3000; it++) begin
            stall   = ($urandom_range(0, 6) == 0);
            br      = $urandom_range(0, 1) == 1;
            jimm    = !br && ($urandom_range(0, 3) == 0);
            jreg    = !br && !jimm && ($urandom_range(0, 3) == 0);
            cc      = 3'($urandom_range(0, 7));
            zr      = $urandom_range(0, 1) == 1;
            ov      = $urandom_range(0, 1) == 1;
            neg     = $urandom_range(0, 1) == 1;
            clk_z   = $urandom_range(0, 1) == 1;
            clk_nv  = $urandom_range(0, 1) == 1;
            pred_in = $urandom_range(0, 1) == 1;
            pc_IF   = PC_W'($urandom_range(0, 255));
            pc_EX   = (it % 3 == 0) ? pc_IF : PC_W'($urandom_range(0, 255));
            push    = ($urandom_range(0, 3) == 0);
            pop     = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            step();
            rst = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
